// File: rtl/alarm_pkg.sv
// Shared types and constants for the sequential door alarm.
// State encoding is fixed because state_o drives the SEG/lcd debug fields directly.
package alarm_pkg;

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StExit     = 3'd1,
    StArmed    = 3'd2,
    StEntry    = 3'd3,
    StAlarm    = 3'd4
  } state_t;

  localparam int unsigned DefaultExitCycles  = 4;
  localparam int unsigned DefaultEntryCycles = 3;
  localparam int unsigned DefaultSirenCycles = 8;
  localparam int unsigned DefaultCntW        = 4;
  localparam int unsigned DefaultEvtW        = 4;

  // Same arming condition as the legacy combinational alarm.
  function automatic logic arm_request(input logic interruptor, input logic relogio);
    return interruptor | ~relogio;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Synchronous load/decrement down-counter with a zero flag.
// Load wins over decrement; decrement stops at zero.
module delay_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Door alarm sequencer: exit delay, armed, entry delay, timed siren with acknowledge,
// and a saturating alarm event counter. Moore FSM sharing one down-counter.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned EXIT_CYCLES  = DefaultExitCycles,
  parameter int unsigned ENTRY_CYCLES = DefaultEntryCycles,
  parameter int unsigned SIREN_CYCLES = DefaultSirenCycles,
  parameter int unsigned CNT_W        = DefaultCntW,
  parameter int unsigned EVT_W        = DefaultEvtW
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             porta,
  input  logic             relogio,
  input  logic             interruptor,
  input  logic             ack,
  output logic             siren,
  output logic             armed,
  output logic             arm_fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] count_o,
  output logic [EVT_W-1:0] alarm_evt
);

  localparam logic [CNT_W-1:0] ExitLoad  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SirenLoad = CNT_W'(SIREN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [EVT_W-1:0] evt_q;
  logic             siren_q, armed_q, fault_q;

  logic             arm_req;
  logic             fault_d;
  logic             evt_inc;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val, tmr_count;

  assign arm_req = arm_request(interruptor, relogio);

  delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .count_o    (tmr_count),
    .zero_o     (tmr_zero)
  );

  // Next state and timer command. Any move into an untimed state clears the timer.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    evt_inc  = 1'b0;

    if (!arm_req) begin
      state_d  = StDisarmed;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        StDisarmed: begin
          if (!porta) begin
            state_d  = StExit;
            tmr_load = 1'b1;
            tmr_val  = ExitLoad;
          end
        end
        StExit: begin
          // Any open-door cycle restarts the full exit window.
          if (porta) begin
            tmr_load = 1'b1;
            tmr_val  = ExitLoad;
          end else if (tmr_zero) begin
            state_d  = StArmed;
            tmr_load = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        StArmed: begin
          if (porta) begin
            state_d  = StEntry;
            tmr_load = 1'b1;
            tmr_val  = EntryLoad;
          end
        end
        StEntry: begin
          // Closing the door again does not cancel the entry delay.
          if (tmr_zero) begin
            state_d  = StAlarm;
            tmr_load = 1'b1;
            tmr_val  = SirenLoad;
            evt_inc  = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        StAlarm: begin
          if (ack) begin
            state_d  = StDisarmed;
            tmr_load = 1'b1;
          end else if (tmr_zero) begin
            if (porta) begin
              tmr_load = 1'b1;
              tmr_val  = SirenLoad;
              evt_inc  = 1'b1;
            end else begin
              state_d  = StArmed;
              tmr_load = 1'b1;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: begin
          state_d  = StDisarmed;
          tmr_load = 1'b1;
        end
      endcase
    end
  end

  assign fault_d = (state_q == StDisarmed) && arm_req && porta;

  // Outputs are registered from state_d so they always match the state register.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state_q <= StDisarmed;
      evt_q   <= '0;
      siren_q <= 1'b0;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      siren_q <= (state_d == StAlarm);
      armed_q <= (state_d == StArmed) || (state_d == StEntry);
      fault_q <= fault_d;
      if (evt_inc && (evt_q != {EVT_W{1'b1}})) begin
        evt_q <= evt_q + 1'b1;
      end
    end
  end

  assign siren     = siren_q;
  assign armed     = armed_q;
  assign arm_fault = fault_q;
  assign state_o   = state_q;
  assign count_o   = tmr_count;
  assign alarm_evt = evt_q;

endmodule
